// File: rtl/bec_la_pkg.sv
// Shared types and LA bit map for the BEC logic-analyzer bridge.
package bec_la_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RUN  = 3'd1,
      ST_DONE = 3'd2,
      ST_ERR  = 3'd3
   } state_t;

   localparam int FIELD_W_DFLT = 163;
   localparam int WORD_W_DFLT  = 32;
   localparam int N_WORDS_DFLT = 6;
   localparam int N_SLOTS_DFLT = 6;

   // LA input map
   localparam int LA_WDATA_LSB = 0;
   localparam int LA_ADDR_LSB  = 32;
   localparam int LA_ADDR_BITS = 7;
   localparam int LA_SLOT_BITS = 4;
   localparam int LA_WORD_BITS = 3;
   localparam int LA_WR_TGL    = 40;
   localparam int LA_START_TGL = 41;
   localparam int LA_CLR_TGL   = 42;

   // LA output map
   localparam int LA_RDATA_LSB  = 0;
   localparam int LA_STATE_LSB  = 32;
   localparam int LA_STATE_BITS = 3;
   localparam int LA_BUSY       = 35;
   localparam int LA_DONE       = 36;
   localparam int LA_ERR        = 37;
   localparam int LA_WRCNT_LSB  = 40;
   localparam int LA_WRCNT_BITS = 8;

   // Bits of the field element that land in the final operand word.
   function automatic int last_word_bits(input int field_w, input int word_w, input int n_words);
      return field_w - (n_words - 1) * word_w;
   endfunction

endpackage

// File: rtl/bec_operand_bank.sv
// Word-addressed operand store with a per-word load mask; the final word of each
// slot keeps only the field bits that remain, so the flattened bank is dense.
module bec_operand_bank
   import bec_la_pkg::*;
#(
   parameter int FIELD_W = FIELD_W_DFLT,
   parameter int WORD_W  = WORD_W_DFLT,
   parameter int N_WORDS = N_WORDS_DFLT,
   parameter int N_SLOTS = N_SLOTS_DFLT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [LA_SLOT_BITS-1:0]      wr_slot,
   input  logic [LA_WORD_BITS-1:0]      wr_word,
   input  logic [WORD_W-1:0]            wr_data,
   input  logic                         clr_mask,
   output logic                         all_loaded,
   output logic [N_SLOTS*FIELD_W-1:0]   operands
);

   localparam int LAST_W = last_word_bits(FIELD_W, WORD_W, N_WORDS);

   logic [N_SLOTS*N_WORDS-1:0] loaded;

   for (genvar s = 0; s < N_SLOTS; s++) begin : g_slot
      for (genvar w = 0; w < N_WORDS; w++) begin : g_word
         localparam int KEEP = (w == N_WORDS - 1) ? LAST_W : WORD_W;

         logic [KEEP-1:0] word_q;
         logic            loaded_q;
         logic            hit;

         assign hit = wr_en && (wr_slot == LA_SLOT_BITS'(s)) && (wr_word == LA_WORD_BITS'(w));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               word_q   <= '0;
               loaded_q <= 1'b0;
            end else begin
               if (hit) begin
                  word_q <= wr_data[KEEP-1:0];
               end
               // Clearing the mask leaves the operand words intact for a later re-run.
               if (clr_mask) begin
                  loaded_q <= 1'b0;
               end else if (hit) begin
                  loaded_q <= 1'b1;
               end
            end
         end

         assign operands[s*FIELD_W + w*WORD_W +: KEEP] = word_q;
         assign loaded[s*N_WORDS + w]                  = loaded_q;
      end
   end

   assign all_loaded = &loaded;

endmodule

// File: rtl/la_bec_bridge.sv
// LA bridge to the BEC core: assembles operands from toggle-qualified LA writes,
// launches the core under a timeout, and returns result words plus status on la_data_out.
module la_bec_bridge
   import bec_la_pkg::*;
#(
   parameter int FIELD_W     = FIELD_W_DFLT,
   parameter int WORD_W      = WORD_W_DFLT,
   parameter int N_WORDS     = N_WORDS_DFLT,
   parameter int N_SLOTS     = N_SLOTS_DFLT,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   input  logic [63:0]                  la_data_in,
   input  logic [63:0]                  la_oenb,
   output logic [63:0]                  la_data_out,
   output logic [N_SLOTS*FIELD_W-1:0]   bec_operands,
   output logic                         bec_start,
   input  logic                         bec_done,
   input  logic [2*FIELD_W-1:0]         bec_result
);

   localparam int EXT_W  = N_WORDS * WORD_W;
   localparam int TCNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   logic [WORD_W-1:0]       wdata;
   logic [LA_ADDR_BITS-1:0] addr;
   logic [LA_SLOT_BITS-1:0] slot;
   logic [LA_WORD_BITS-1:0] word;
   logic                    addr_ok;

   logic [2:0] tgl_cur;
   logic [2:0] tgl_vld;
   logic [2:0] tgl_prev;
   logic [2:0] tgl_evt;
   logic       clr_evt;
   logic       start_evt;
   logic       wr_evt;

   state_t state_q;
   state_t state_d;
   logic   launch;
   logic   err_set;
   logic   bank_wr;
   logic   cnt_inc;
   logic   capture;

   logic                    start_q;
   logic                    err_q;
   logic [LA_WRCNT_BITS-1:0] wr_cnt_q;
   logic [TCNT_W-1:0]       tcnt_q;
   logic [FIELD_W-1:0]      res_w_q;
   logic [FIELD_W-1:0]      res_z_q;
   logic [EXT_W-1:0]        res_w_ext;
   logic [EXT_W-1:0]        res_z_ext;
   logic [WORD_W-1:0]       rdata_d;
   logic [WORD_W-1:0]       rdata_q;
   logic                    all_loaded;
   logic [63:0]             la_out;
   logic                    unused_la;

   // Data bits whose oenb is high are not driven by management and read as 0.
   assign wdata   = la_data_in[LA_WDATA_LSB +: WORD_W] & ~la_oenb[LA_WDATA_LSB +: WORD_W];
   assign addr    = la_data_in[LA_ADDR_LSB +: LA_ADDR_BITS] & ~la_oenb[LA_ADDR_LSB +: LA_ADDR_BITS];
   assign slot    = addr[LA_ADDR_BITS-1 -: LA_SLOT_BITS];
   assign word    = addr[LA_WORD_BITS-1:0];
   assign addr_ok = (int'(slot) < N_SLOTS) && (int'(word) < N_WORDS);

   assign unused_la = ^{la_data_in[63:43], la_data_in[39], la_oenb[63:43], la_oenb[39]};

   assign tgl_cur = {la_data_in[LA_CLR_TGL], la_data_in[LA_START_TGL], la_data_in[LA_WR_TGL]};
   assign tgl_vld = ~{la_oenb[LA_CLR_TGL], la_oenb[LA_START_TGL], la_oenb[LA_WR_TGL]};
   assign tgl_evt = tgl_vld & (tgl_cur ^ tgl_prev);

   // CLR beats START beats WR; losers are dropped, not queued.
   assign clr_evt   = tgl_evt[2];
   assign start_evt = tgl_evt[1] & ~tgl_evt[2];
   assign wr_evt    = tgl_evt[0] & ~tgl_evt[1] & ~tgl_evt[2];

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      err_set = 1'b0;
      bank_wr = 1'b0;
      cnt_inc = 1'b0;
      capture = 1'b0;
      if (clr_evt) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_evt) begin
                  if (all_loaded) begin
                     state_d = ST_RUN;
                     launch  = 1'b1;
                  end else begin
                     state_d = ST_ERR;
                     err_set = 1'b1;
                  end
               end else if (wr_evt) begin
                  if (addr_ok) begin
                     bank_wr = 1'b1;
                     cnt_inc = 1'b1;
                  end else begin
                     err_set = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (bec_done) begin
                  capture = 1'b1;
                  state_d = ST_DONE;
               end else if (tcnt_q == TCNT_W'(TIMEOUT_CYC - 1)) begin
                  state_d = ST_ERR;
                  err_set = 1'b1;
               end
               if (wr_evt) begin
                  err_set = 1'b1;
               end
            end
            ST_ERR: begin
               state_d = ST_ERR;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         tgl_prev <= '0;
         start_q  <= 1'b0;
         tcnt_q   <= '0;
         err_q    <= 1'b0;
         wr_cnt_q <= '0;
         res_w_q  <= '0;
         res_z_q  <= '0;
         rdata_q  <= '0;
      end else begin
         tgl_prev <= (tgl_vld & tgl_cur) | (~tgl_vld & tgl_prev);
         start_q  <= launch;
         rdata_q  <= rdata_d;
         if (launch) begin
            tcnt_q <= '0;
         end else if (state_q == ST_RUN) begin
            tcnt_q <= tcnt_q + 1'b1;
         end
         if (clr_evt) begin
            err_q    <= 1'b0;
            wr_cnt_q <= '0;
            res_w_q  <= '0;
            res_z_q  <= '0;
         end else begin
            if (err_set) begin
               err_q <= 1'b1;
            end
            if (cnt_inc) begin
               wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            if (capture) begin
               res_w_q <= bec_result[FIELD_W-1:0];
               res_z_q <= bec_result[2*FIELD_W-1:FIELD_W];
            end
         end
      end
   end

   assign res_w_ext = EXT_W'(res_w_q);
   assign res_z_ext = EXT_W'(res_z_q);

   always_comb begin
      rdata_d = '0;
      for (int i = 0; i < N_WORDS; i++) begin
         if (word == LA_WORD_BITS'(i)) begin
            if (slot == LA_SLOT_BITS'(0)) begin
               rdata_d = res_w_ext[i*WORD_W +: WORD_W];
            end else if (slot == LA_SLOT_BITS'(1)) begin
               rdata_d = res_z_ext[i*WORD_W +: WORD_W];
            end
         end
      end
   end

   always_comb begin
      la_out                                      = '0;
      la_out[LA_RDATA_LSB +: WORD_W]              = rdata_q;
      la_out[LA_STATE_LSB +: LA_STATE_BITS]       = state_q;
      la_out[LA_BUSY]                             = (state_q == ST_RUN);
      la_out[LA_DONE]                             = (state_q == ST_DONE);
      la_out[LA_ERR]                              = err_q;
      la_out[LA_WRCNT_LSB +: LA_WRCNT_BITS]       = wr_cnt_q;
   end

   assign la_data_out = la_out;
   assign bec_start   = start_q;

   bec_operand_bank #(
      .FIELD_W (FIELD_W),
      .WORD_W  (WORD_W),
      .N_WORDS (N_WORDS),
      .N_SLOTS (N_SLOTS)
   ) u_bank (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .wr_en      (bank_wr),
      .wr_slot    (slot),
      .wr_word    (word),
      .wr_data    (wdata),
      .clr_mask   (clr_evt),
      .all_loaded (all_loaded),
      .operands   (bec_operands)
   );

endmodule

// File: tb/tb_la_bec_bridge.sv
// Directed bench for la_bec_bridge: operand load, run/done, read-back, errors, timeout, priority, reset.
module tb_la_bec_bridge;

   localparam int FW = 163;

   logic            clk;
   logic            rst;
   logic [63:0]     la_in;
   logic [63:0]     oenb;
   logic [63:0]     la_out;
   logic [6*FW-1:0] operands;
   logic            start;
   logic            done_in;
   logic [2*FW-1:0] result;

   int n_checks  = 0;
   int n_errs    = 0;
   int start_cnt = 0;
   int starts0;

   logic [FW-1:0] w_val;
   logic [FW-1:0] z_val;

   la_bec_bridge #(.TIMEOUT_CYC(100)) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .la_data_in   (la_in),
      .la_oenb      (oenb),
      .la_data_out  (la_out),
      .bec_operands (operands),
      .bec_start    (start),
      .bec_done     (done_in),
      .bec_result   (result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (start === 1'b1) start_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [6:0] a, input logic [31:0] d);
      la_in[31:0]  = d;
      la_in[38:32] = a;
      la_in[40]    = ~la_in[40];
      tick();
   endtask

   task automatic pulse_start();
      la_in[41] = ~la_in[41];
      tick();
   endtask

   task automatic pulse_clr();
      la_in[42] = ~la_in[42];
      tick();
   endtask

   task automatic write_all(input int skip_s, input int skip_w);
      logic [6:0] a;
      for (int s = 0; s < 6; s++) begin
         for (int w = 0; w < 6; w++) begin
            if (!(s == skip_s && w == skip_w)) begin
               a = 7'(s * 8 + w);
               wr(a, 32'hA5A5_0000 + {25'd0, a});
            end
         end
      end
   endtask

   initial begin
      rst     = 1'b0;
      la_in   = '0;
      oenb    = '0;
      done_in = 1'b0;
      result  = '0;
      w_val   = FW'(32'h1234);
      z_val   = FW'(32'h5678) | (FW'(3'h7) << 160);

      #1 rst = 1'b1;
      #1;
      check("rst_la_out", la_out, 64'h0);
      check("rst_start", {63'd0, start}, 64'h0);
      check("rst_operands", {63'd0, operands == '0}, 64'h1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      tick();
      check("idle_after_rst", la_out, 64'h0);

      // full load then run
      write_all(-1, -1);
      check("wr_cnt_36", {56'd0, la_out[47:40]}, 64'd36);
      check("no_err_after_load", {63'd0, la_out[37]}, 64'h0);
      check("op_s0w0", {32'd0, operands[31:0]}, 64'hA5A5_0000);
      check("op_s2w1", {32'd0, operands[2*FW+32 +: 32]}, 64'hA5A5_0011);
      check("op_s5w5_trunc", {61'd0, operands[5*FW+160 +: 3]}, 64'h5);

      result  = {z_val, w_val};
      starts0 = start_cnt;
      pulse_start();
      check("start_pulse", {63'd0, start}, 64'h1);
      check("run_status", {59'd0, la_out[36:32]}, 64'b01001);
      tick();
      check("start_one_cycle", {63'd0, start}, 64'h0);
      repeat (48) tick();
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      check("done_status", {59'd0, la_out[36:32]}, 64'b10010);
      check("one_start", 64'(start_cnt - starts0), 64'd1);

      // result read-back, 1-cycle latency
      la_in[38:32] = 7'h00;
      tick();
      check("rd_w0", {32'd0, la_out[31:0]}, 64'h1234);
      la_in[38:32] = 7'h08;
      check("rd_latency", {32'd0, la_out[31:0]}, 64'h1234);
      tick();
      check("rd_z0", {32'd0, la_out[31:0]}, 64'h5678);
      la_in[38:32] = 7'h0D;
      tick();
      check("rd_z5_zext", {32'd0, la_out[31:0]}, 64'h7);
      la_in[38:32] = 7'h10;
      tick();
      check("rd_slot2_zero", {32'd0, la_out[31:0]}, 64'h0);

      // WR+START+CLR together in DONE
      starts0      = start_cnt;
      la_in[31:0]  = 32'hDEAD_BEEF;
      la_in[38:32] = 7'h00;
      la_in[40]    = ~la_in[40];
      la_in[41]    = ~la_in[41];
      la_in[42]    = ~la_in[42];
      tick();
      check("prio_state_idle", {58'd0, la_out[37:32]}, 64'h0);
      tick();
      check("prio_no_start", 64'(start_cnt - starts0), 64'd0);
      check("prio_no_store", {32'd0, operands[31:0]}, 64'hA5A5_0000);
      check("prio_wr_cnt_clr", {56'd0, la_out[47:40]}, 64'd0);
      check("prio_result_clr", {32'd0, la_out[31:0]}, 64'h0);

      // incomplete mask
      write_all(2, 4);
      check("wr_cnt_35", {56'd0, la_out[47:40]}, 64'd35);
      starts0 = start_cnt;
      pulse_start();
      check("incomplete_err", {58'd0, la_out[37:32]}, 64'b100011);
      tick();
      check("incomplete_no_start", 64'(start_cnt - starts0), 64'd0);
      pulse_clr();
      check("clr_to_idle", {58'd0, la_out[37:32]}, 64'h0);

      // write during RUN, then timeout
      write_all(-1, -1);
      starts0 = start_cnt;
      pulse_start();
      wr(7'h00, 32'hFFFF_FFFF);
      check("run_wr_err", {58'd0, la_out[37:32]}, 64'b101001);
      check("run_wr_cnt", {56'd0, la_out[47:40]}, 64'd36);
      check("run_wr_bank", {32'd0, operands[31:0]}, 64'hA5A5_0000);
      repeat (98) tick();
      check("still_run_99", {61'd0, la_out[34:32]}, 64'd1);
      tick();
      check("timeout_err_100", {61'd0, la_out[34:32]}, 64'd3);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      tick();
      check("late_done_ignored", {59'd0, la_out[36:32]}, 64'b00011);
      check("late_done_no_capture", {32'd0, la_out[31:0]}, 64'h0);
      check("timeout_one_start", 64'(start_cnt - starts0), 64'd1);
      pulse_clr();

      // START toggled while its oenb is high
      starts0     = start_cnt;
      oenb[41]    = 1'b1;
      la_in[41]   = ~la_in[41];
      repeat (3) tick();
      check("oenb_no_event", {58'd0, la_out[37:32]}, 64'h0);
      la_in[41]   = ~la_in[41];
      oenb[41]    = 1'b0;
      tick();
      check("oenb_still_idle", {58'd0, la_out[37:32]}, 64'h0);
      check("oenb_no_start", 64'(start_cnt - starts0), 64'd0);

      // out-of-range write
      wr(7'h30, 32'h1);
      check("oor_err", {58'd0, la_out[37:32]}, 64'b100000);
      check("oor_no_count", {56'd0, la_out[47:40]}, 64'd0);
      pulse_clr();

      // async reset mid-RUN
      write_all(-1, -1);
      pulse_start();
      repeat (9) tick();
      check("pre_rst_run", {61'd0, la_out[34:32]}, 64'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_la_out", la_out, 64'h0);
      check("async_rst_start", {63'd0, start}, 64'h0);
      check("async_rst_operands", {63'd0, operands == '0}, 64'h1);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/la_bec_bridge.md
Name: la_bec_bridge

Overview:
- Logic-analyzer bridge between the management core and the binary-Edwards-curve (BEC) core in the user project.
- Accepts operand words the firmware writes over la_data_in and assembles them into full-width field operands.
- Starts the BEC core, waits for its done handshake, and captures the result.
- Returns result words and status on la_data_out; firmware mirrors the status onto its checkbits GPIO codes.

Parameters:
- FIELD_W, 163, field element width in bits
- WORD_W, 32, LA data word width
- N_WORDS, 6, words per operand, ceil(FIELD_W/WORD_W)
- N_SLOTS, 6, operand slots: 0=d, 1=w1, 2=z1, 3=w2, 4=z2, 5=key
- TIMEOUT_CYC, 200000, cycles allowed from bec_start to bec_done

Ports:
- wb_clk_i  in  1  core clock, single domain
- wb_rst_i  in  1  asynchronous, active-high reset
- la_data_in  in  64  management-driven LA bits
- la_oenb  in  64  LA output-enable-bar; an input bit is valid only while its oenb bit is 0
- la_data_out  out  64  read data and status to management
- bec_operands  out  N_SLOTS*FIELD_W  flattened operand bank; slot s occupies [s*FIELD_W +: FIELD_W]
- bec_start  out  1  one-cycle start pulse
- bec_done  in  1  one-cycle completion pulse from the BEC core
- bec_result  in  2*FIELD_W  {z, w} result from the BEC core

Behaviour:
- LA input map:
  - [31:0] WDATA
  - [38:32] ADDR, with slot = ADDR[6:3] and word = ADDR[2:0]
  - [40] WR_TGL
  - [41] START_TGL
  - [42] CLR_TGL
- Each toggle bit is qualified by its oenb bit. An event is a change from the registered previous value, which gives one event per toggle edge. The previous-value registers reset to 0.
- LA output map:
  - [31:0] RDATA
  - [34:32] state
  - [35] busy
  - [36] done
  - [37] err
  - [47:40] wr_cnt
  - [63:48] = 0
- Reset values: every output and register is 0; state = IDLE; slot load mask = 0.
- Write event, IDLE or DONE only:
  - Stores WDATA into bank[slot][word] and sets mask bit {slot, word}.
  - Word N_WORDS-1 keeps only FIELD_W-(N_WORDS-1)*WORD_W bits (3 bits at defaults); upper bits are dropped.
  - wr_cnt increments, wrapping mod 256.
  - A slot >= N_SLOTS or word >= N_WORDS is not stored and sets err. err is sticky; state does not change.
- Write event in RUN: ignored and sets err; wr_cnt does not change.
- Read path: RDATA is registered with 1-cycle latency from ADDR.
  - slot 0 returns result w, slot 1 returns result z, each at the word given by ADDR.
  - Any other ADDR returns 0.
  - The top result word is zero-extended.
- FSM, states IDLE=0, RUN=1, DONE=2, ERR=3:
  - IDLE, START event, mask all ones: go to RUN; bec_start = 1 for exactly the next cycle; timeout counter cleared.
  - IDLE, START event, mask incomplete: go to ERR; err = 1.
  - RUN: timeout counter increments each cycle.
  - RUN, bec_done: capture bec_result into the result registers; go to DONE.
  - RUN, counter reaches TIMEOUT_CYC-1 with no bec_done: go to ERR.
  - DONE, START event: re-run with the retained operands, same rule as IDLE; the mask is not cleared by completion.
  - ERR: accepts only a CLR event.
- busy = (state == RUN). done = (state == DONE).
- CLR event, any state:
  - Next state IDLE; mask, err and results cleared; operands retained; wr_cnt cleared.
  - In RUN, a late bec_done is ignored.
- Simultaneous events in the same cycle: CLR beats START beats WR. The lower-priority events are discarded, not deferred.
- bec_done outside RUN is ignored.
- wb_rst_i mid-RUN: immediate return to reset values; bec_start is never left high.

Decomposition:
- Package bec_la_pkg holds:
  - the state enum
  - LA bit-position constants (WDATA, ADDR, toggle bits, status bits)
  - FIELD_W, WORD_W, N_WORDS, N_SLOTS defaults and the last-word width function
- Sub-module bec_operand_bank: word-addressed write port, load mask, all-loaded flag and flattened output. The FSM, toggle detection and read mux stay in la_bec_bridge.

Test Plan:
- Write all 36 words with WDATA = 0xA5A5_0000 + ADDR, then START -> bec_start pulses once 1 cycle after the event; wr_cnt = 36; slot 5 word 5 stored as 0x5 (3 bits kept).
- Stub core returns done after 50 cycles with w = 0x1234, z = 0x5678 -> state DONE; ADDR = 0x00 reads 0x1234 and ADDR = 0x08 reads 0x5678, each 1 cycle after ADDR changes.
- Write 35 words (skip slot 2 word 4), then START -> state ERR, err = 1, no bec_start; then CLR -> IDLE, err = 0, mask empty.
- TIMEOUT_CYC = 100, core never responds -> ERR on cycle 100 after bec_start; a later bec_done causes no change.
- WR, START and CLR events in the same cycle in DONE -> IDLE, no bec_start, no store. Write during RUN -> err = 1, bank unchanged.
- Toggle START with oenb[41] = 1 -> no event. Reset asserted 10 cycles into RUN -> all outputs 0 asynchronously.
